// File: rtl/dm_responder_pkg.sv
// Shared data-memory constants: access-type codes and the responder FSM encoding,
// common to the pipeline controller and the data-memory responder.
package dm_responder_pkg;

   typedef enum logic [2:0] {
      DM_WORD   = 3'b000,
      DM_HALF   = 3'b001,
      DM_HALF_U = 3'b010,
      DM_BYTE   = 3'b011,
      DM_BYTE_U = 3'b100
   } dm_type_e;

   typedef enum logic [1:0] {
      IDLE = 2'b00,
      BUSY = 2'b01,
      RESP = 2'b10
   } dm_state_e;

   function automatic logic is_half(input logic [2:0] dmtype);
      return (dmtype == DM_HALF) || (dmtype == DM_HALF_U);
   endfunction

endpackage

// File: rtl/dm_lane_align.sv
// Combinational byte-lane steering for the data memory: shifts store mask/data up
// to the addressed byte, shifts the read word down, and flags misaligned accesses.
module dm_lane_align
   import dm_responder_pkg::*;
(
   input  logic [2:0]  dmtype,
   input  logic [3:0]  wea,
   input  logic [1:0]  offset,
   input  logic [31:0] wdata,
   input  logic [31:0] rword,
   output logic [3:0]  lanes,
   output logic [31:0] wdata_sh,
   output logic [31:0] rdata_sh,
   output logic        misaligned
);

   always_comb begin
      lanes      = wea << offset;
      wdata_sh   = wdata << {offset, 3'b000};
      rdata_sh   = rword >> {offset, 3'b000};
      misaligned = (is_half(dmtype) && offset[0]) ||
                   ((dmtype == DM_WORD) && (offset != 2'b00));
   end

endmodule

// File: rtl/dm_responder.sv
// Single-port data-memory responder: writes complete at acceptance, reads return
// after RD_LATENCY cycles, misaligned accesses answer immediately with an error.
module dm_responder
   import dm_responder_pkg::*;
#(
   parameter int DEPTH_WORDS = 1024,
   parameter int RD_LATENCY  = 2
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req_valid,
   input  logic [3:0]  req_wea,
   input  logic [31:0] req_addr,
   input  logic [31:0] req_wdata,
   input  logic [2:0]  req_dmtype,
   output logic        req_ready,
   output logic        resp_valid,
   output logic [31:0] resp_rdata,
   output logic        resp_err,
   output logic        stall
);

   localparam int AW = $clog2(DEPTH_WORDS);

   logic [31:0]   mem [DEPTH_WORDS];
   dm_state_e     state, state_next;
   logic [1:0]    cnt, cnt_next;
   logic [AW-1:0] idx;
   logic          accept, is_write, misaligned;
   logic [3:0]    lanes;
   logic [31:0]   wdata_sh, rdata_sh, rdata_q;
   logic          err_q;
   logic          unused_addr;

   assign idx         = req_addr[AW+1:2];
   assign unused_addr = ^req_addr[31:AW+2];
   assign is_write    = (req_wea != 4'b0000);
   assign req_ready   = (state == IDLE);
   assign accept      = req_valid && req_ready;

   dm_lane_align u_align (
      .dmtype     (req_dmtype),
      .wea        (req_wea),
      .offset     (req_addr[1:0]),
      .wdata      (req_wdata),
      .rword      (mem[idx]),
      .lanes      (lanes),
      .wdata_sh   (wdata_sh),
      .rdata_sh   (rdata_sh),
      .misaligned (misaligned)
   );

   // Writes and rejected accesses answer next cycle; reads wait out the latency in BUSY.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      case (state)
         IDLE: begin
            if (accept) begin
               if (is_write || misaligned) begin
                  state_next = RESP;
               end else begin
                  state_next = BUSY;
                  cnt_next   = 2'(RD_LATENCY - 1);
               end
            end
         end
         BUSY: begin
            if (cnt == 2'd0) state_next = RESP;
            else             cnt_next   = cnt - 2'd1;
         end
         RESP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 2'd0;
         rdata_q <= 32'd0;
         err_q   <= 1'b0;
      end else begin
         state <= state_next;
         cnt   <= cnt_next;
         if (accept) begin
            rdata_q <= (is_write || misaligned) ? 32'd0 : rdata_sh;
            err_q   <= misaligned;
         end
      end
   end

   // Array contents survive reset; a write coinciding with reset is dropped.
   always_ff @(posedge clk) begin
      if (accept && is_write && !misaligned && !rst) begin
         for (int b = 0; b < 4; b++) begin
            if (lanes[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
         end
      end
   end

   assign resp_valid = (state == RESP);
   assign resp_err   = resp_valid && err_q;
   assign resp_rdata = rdata_q;
   assign stall      = (state != IDLE) || (req_valid && !is_write);

endmodule

// File: doc/dm_responder.md
DM_RESPONDER -- requirements
Module: dm_responder

Interface
REQ-001 SHALL have parameter DEPTH_WORDS, default 1024, meaning the number of 32-bit words in the array (power of two).
REQ-002 SHALL have parameter RD_LATENCY, default 2, meaning the number of cycles from read acceptance to resp_valid (legal range 1..4).
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, asynchronous and active-high.
REQ-005 SHALL have port req_valid, input, 1 bit: a request is present.
REQ-006 SHALL have port req_wea, input, 4 bits: unshifted byte write mask from the pipeline (1111 word, 0011 half, 0001 byte, 0000 read).
REQ-007 SHALL have port req_addr, input, 32 bits: byte address.
REQ-008 SHALL have port req_wdata, input, 32 bits: store data, LSB-aligned.
REQ-009 SHALL have port req_dmtype, input, 3 bits: access type, using the shared DMType constants.
REQ-010 SHALL have port req_ready, output, 1 bit: a request is accepted this cycle.
REQ-011 SHALL have port resp_valid, output, 1 bit: one-cycle response pulse.
REQ-012 SHALL have port resp_rdata, output, 32 bits: raw read data, shifted so the addressed byte sits at bit 0 (no extension).
REQ-013 SHALL have port resp_err, output, 1 bit: the request was misaligned and rejected; valid with resp_valid.
REQ-014 SHALL have port stall, output, 1 bit: the pipeline must hold.

Function
REQ-015 SHALL implement FSM states IDLE, BUSY and RESP; req_ready SHALL be 1 only in IDLE.
REQ-016 SHALL accept a request on an edge where req_valid=1 and req_ready=1.
REQ-017 SHALL treat an accepted request as a write when req_wea!=0; the array SHALL update at the acceptance edge with lanes = req_wea<<addr[1:0] and data = req_wdata<<(8*addr[1:0]); the FSM SHALL go to RESP.
REQ-018 SHALL treat an accepted request as a read when req_wea==0; the FSM SHALL go to BUSY and load a counter with RD_LATENCY-1.
REQ-019 SHALL, in BUSY, decrement the counter each cycle and go to RESP when it is 0; with RD_LATENCY=1, BUSY SHALL last one cycle.
REQ-020 SHALL assert resp_valid for exactly the one cycle spent in RESP, then return to IDLE; there is no backpressure.
REQ-021 SHALL, for reads, drive resp_rdata = word >> (8*addr[1:0]), with the word sampled at acceptance; for writes, SHALL drive resp_rdata = 0.
REQ-022 SHALL treat a halfword access with addr[0]=1, or a word access with addr[1:0]!=0, as misaligned: no array change, go straight to RESP, resp_err=1, resp_rdata=0.
REQ-023 SHALL index the array with addr[log2(DEPTH_WORDS)+1:2]; higher address bits are ignored, so addresses wrap.
REQ-024 SHALL drive stall = 1 whenever state != IDLE, plus combinationally in IDLE when req_valid=1 and the request is a read.
REQ-025 SHALL ignore req_valid while not in IDLE, with no queuing.
REQ-026 SHALL deassert resp_valid and resp_err whenever they are not in RESP.

Reset
REQ-027 SHALL, on rst, set the state to IDLE, the counter to 0, resp_valid=0, resp_err=0 and resp_rdata=0 immediately.
REQ-028 SHALL drop any in-flight request on reset mid-operation, with no response emitted.
REQ-029 SHALL NOT reset array contents; a write accepted on the same edge as rst rising is discarded.

Structure
REQ-030 SHALL source the DMType codes and the state encoding (IDLE/BUSY/RESP) from the shared constants header used by ctrl.
REQ-031 SHALL place lane shifting and the misalignment check in one combinational sub-module, dm_lane_align.

Verification
REQ-032 SHALL cover a word write then read: write 0xDEADBEEF to 0x10, then read 0x10 with RD_LATENCY=2 -> resp_valid 2 cycles after acceptance, rdata=0xDEADBEEF, stall high throughout.
REQ-033 SHALL cover a byte write at offset: write byte 0x5A to 0x13 over 0x00000000 -> word read of 0x10 returns 0x5A000000; byte read of 0x13 returns 0x0000005A.
REQ-034 SHALL cover a misaligned halfword: write to 0x21 -> next cycle resp_valid=1, resp_err=1, word at 0x20 unchanged.
REQ-035 SHALL cover wrap: with DEPTH_WORDS=1024, write 0x11111111 to 0x1004 -> word read of 0x0004 returns 0x11111111.
REQ-036 SHALL cover reset mid-read: assert rst in BUSY -> no resp_valid, state IDLE, req_ready=1 on the first cycle after rst falls.
REQ-037 SHALL cover back-to-back requests: a second request held during BUSY -> accepted only after RESP, with exactly one response per request.
